// File: rtl/dmem_store_buffer_responder.sv
// Data-memory responder: single-ported word array fronted by a posted FIFO store buffer.
// Latency: loads are combinational (same cycle, with store-to-load forwarding); stores post on the edge.
// Backpressure: mem_busy refuses a store only when the buffer is full; a drain frees a slot that edge.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   R_en / W_en                   load / store request this cycle
//   RW_type_mem                   func3 access type (b, h, w, bu, hu; undefined codes act as word)
//   ram_addr, store_data          byte address, right-aligned store operand
//   load_data                     extended load result (combinational)
//   mem_busy, misalign            store refused / request misaligned and ignored
//   sb_empty, sb_count            store-buffer occupancy
module dmem_store_buffer_responder #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        R_en,
  input  logic                        W_en,
  input  logic [2:0]                  RW_type_mem,
  input  logic [31:0]                 ram_addr,
  input  logic [31:0]                 store_data,
  output logic [31:0]                 load_data,
  output logic                        mem_busy,
  output logic                        misalign,
  output logic                        sb_empty,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       mem_q    [2**ADDR_W];
  logic [ADDR_W-1:0] sb_idx_q [SB_DEPTH];
  logic [31:0]       sb_dat_q [SB_DEPTH];
  logic [3:0]        sb_msk_q [SB_DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Access decode: [1:0]==00 byte, 01 half, anything else word; bit 2 selects zero-extension.
  logic              is_byte, is_half, sgn, mis_raw, full, enq, drain;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] widx;
  logic              unused_addr;

  assign is_byte     = (RW_type_mem[1:0] == 2'b00);
  assign is_half     = (RW_type_mem[1:0] == 2'b01);
  assign sgn         = ~RW_type_mem[2];
  assign lane        = ram_addr[1:0];
  assign widx        = ram_addr[ADDR_W+1:2];
  assign unused_addr = ^ram_addr[31:ADDR_W+2];

  assign mis_raw = is_half ? lane[0] : (!is_byte && lane != 2'b00);
  assign full    = (count_q == CW'(SB_DEPTH));
  // Loads own the array port, so a drain only happens on cycles with no load.
  assign enq     = rst_n && W_en && !mis_raw && !full;
  assign drain   = rst_n && !R_en && (count_q != '0);

  assign misalign = rst_n && (R_en || W_en) && mis_raw;
  assign mem_busy = rst_n && W_en && !mis_raw && full;
  assign sb_empty = !rst_n || (count_q == '0);
  assign sb_count = rst_n ? count_q : '0;

  // Lane-align the store operand and build its byte mask.
  logic [31:0] st_dat;
  logic [3:0]  st_msk;
  always_comb begin
    st_dat = store_data;
    st_msk = 4'b1111;
    if (is_byte) begin
      st_dat = {4{store_data[7:0]}};
      st_msk = 4'b0001 << lane;
    end else if (is_half) begin
      st_dat = {2{store_data[15:0]}};
      st_msk = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Forwarding: walk valid entries oldest to youngest so the youngest matching byte wins.
  logic [31:0]   merged, ld;
  logic [PW-1:0] slot;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  always_comb begin
    merged = mem_q[widx];
    slot   = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head_q + PW'(i);
      if (CW'(i) < count_q && sb_idx_q[slot] == widx) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_msk_q[slot][b]) merged[8*b +: 8] = sb_dat_q[slot][8*b +: 8];
        end
      end
    end
    ld_b = merged[{lane, 3'b000} +: 8];
    ld_h = lane[1] ? merged[31:16] : merged[15:0];
    if (is_byte)      ld = {{24{sgn & ld_b[7]}}, ld_b};
    else if (is_half) ld = {{16{sgn & ld_h[15]}}, ld_h};
    else              ld = merged;
  end

  assign load_data = (rst_n && R_en && !mis_raw) ? ld : 32'h0;

  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(drain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Buffer payload and array are not reset; enq/drain already include rst_n,
  // so reset discards pending stores without touching the array.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_idx_q[tail_q] <= widx;
      sb_dat_q[tail_q] <= st_dat;
      sb_msk_q[tail_q] <= st_msk;
    end
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_msk_q[head_q][b]) mem_q[sb_idx_q[head_q]][8*b +: 8] <= sb_dat_q[head_q][8*b +: 8];
      end
    end
  end

endmodule
